// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry FIFO of {PC, instruction} pairs between fetch and
// decode. Fetch keeps running while decode stalls. FLUSH discards everything
// on a redirect. An empty queue presents an all-zero bubble to decode.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 (and FLUSH is 0). IF_READY and ID_VALID depend only on registered
// occupancy, so neither side sees a combinational path from the other.
// The offering side must hold its payload stable until the transfer occurs.
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FLUSH,
  input  logic              IF_VALID,
  input  logic [ADDR_W-1:0] IF_PC,
  input  logic [DATA_W-1:0] IF_INST,
  output logic              IF_READY,
  input  logic              ID_READY,
  output logic              ID_VALID,
  output logic [ADDR_W-1:0] ID_PC,
  output logic [DATA_W-1:0] ID_INST,
  output logic [CNT_W-1:0]  COUNT
);

  // DEPTH must be a power of two (>= 2) so the pointers wrap for free.
  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [DATA_W-1:0] inst_mem_q [DEPTH];

  logic if_ready;
  logic id_valid;
  logic push;
  logic pop;

  // Full/empty come from the occupancy counter, never from pointer equality.
  assign if_ready = (count_q != FULL_CNT);
  assign id_valid = (count_q != '0);
  assign push     = IF_VALID & if_ready & ~FLUSH;
  assign pop      = id_valid & ID_READY & ~FLUSH;

  // Next pointer/occupancy: flush wins, otherwise push and pop are independent.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
    end
  end

  // Control state: asynchronous reset to empty.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage: contents are don't-care until written, so no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= IF_PC;
      inst_mem_q[wr_ptr_q] <= IF_INST;
    end
  end

  // Head entry straight from the array, zeroed to a bubble when empty.
  assign ID_PC    = id_valid ? pc_mem_q[rd_ptr_q]   : '0;
  assign ID_INST  = id_valid ? inst_mem_q[rd_ptr_q] : '0;
  assign ID_VALID = id_valid;
  assign IF_READY = if_ready;
  assign COUNT    = count_q;

  // Occupancy can never exceed DEPTH or go below zero.
  a_count_range: assert property (@(posedge CLK) disable iff (!RST)
    count_q <= FULL_CNT);
  a_no_overflow: assert property (@(posedge CLK) disable iff (!RST)
    !(push && !pop && count_q == FULL_CNT));
  a_no_underflow: assert property (@(posedge CLK) disable iff (!RST)
    !(pop && count_q == '0));

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed vector table for if_id_queue (DEPTH=4) plus a
// hand-written sequence for asynchronous reset between clock edges.
module tb_if_id_queue;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              flush;
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [DATA_W-1:0] if_inst;
  logic              if_ready;
  logic              id_ready;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [DATA_W-1:0] id_inst;
  logic [CNT_W-1:0]  count;

  if_id_queue #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .CLK     (clk),
    .RST     (rst_n),
    .FLUSH   (flush),
    .IF_VALID(if_valid),
    .IF_PC   (if_pc),
    .IF_INST (if_inst),
    .IF_READY(if_ready),
    .ID_READY(id_ready),
    .ID_VALID(id_valid),
    .ID_PC   (id_pc),
    .ID_INST (id_inst),
    .COUNT   (count)
  );

  // One vector: inputs for a cycle, then outputs expected after its edge.
  typedef struct {
    logic              rst_n;
    logic              flush;
    logic              if_valid;
    logic [ADDR_W-1:0] pc;
    logic              id_ready;
    logic              exp_if_ready;
    logic              exp_id_valid;
    logic [ADDR_W-1:0] exp_pc;
    int                exp_count;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Instruction word tied to its PC so the data path is checked separately.
  function automatic logic [DATA_W-1:0] inst_of(input logic [ADDR_W-1:0] pc);
    return pc ^ 32'h1300_0013;
  endfunction

  function automatic vec_t mk(input logic r, input logic f, input logic v,
                              input logic [ADDR_W-1:0] pc, input logic rdy,
                              input logic e_ird, input logic e_vld,
                              input logic [ADDR_W-1:0] e_pc, input int e_cnt);
    vec_t t;
    t.rst_n = r; t.flush = f; t.if_valid = v; t.pc = pc; t.id_ready = rdy;
    t.exp_if_ready = e_ird; t.exp_id_valid = e_vld;
    t.exp_pc = e_pc; t.exp_count = e_cnt;
    return t;
  endfunction

  // Scoreboard compare
  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
  endtask

  task automatic check_outputs(input int idx, input vec_t t);
    logic [DATA_W-1:0] e_inst;
    e_inst = t.exp_id_valid ? inst_of(t.exp_pc) : '0;
    check($sformatf("v%0d if_ready", idx), 64'(if_ready), 64'(t.exp_if_ready));
    check($sformatf("v%0d id_valid", idx), 64'(id_valid), 64'(t.exp_id_valid));
    check($sformatf("v%0d id_pc", idx),    64'(id_pc),    64'(t.exp_pc));
    check($sformatf("v%0d id_inst", idx),  64'(id_inst),  64'(e_inst));
    check($sformatf("v%0d count", idx),    64'(count),    64'(t.exp_count));
  endtask

  // Driver: apply inputs away from the edge, clock once, sample 1 after.
  task automatic apply(input int idx, input vec_t t);
    rst_n    = t.rst_n;
    flush    = t.flush;
    if_valid = t.if_valid;
    if_pc    = t.pc;
    if_inst  = inst_of(t.pc);
    id_ready = t.id_ready;
    @(posedge clk);
    #1;
    check_outputs(idx, t);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; if_valid = 1'b1; if_pc = 32'h100;
    if_inst = inst_of(32'h100); id_ready = 1'b0;

    //        rst flu ivl pc      rdy  ird vld e_pc    cnt
    // Reset held with an offer present: bubble, empty, ready.
    vecs.push_back(mk(0, 0, 1, 32'h100, 0,  1, 0, 32'h0,   0));
    vecs.push_back(mk(0, 0, 1, 32'h100, 0,  1, 0, 32'h0,   0));
    // Release: first push visible right after its edge.
    vecs.push_back(mk(1, 0, 1, 32'h100, 0,  1, 1, 32'h100, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,   1,  1, 0, 32'h0,   0));
    // Streaming with decode always ready.
    vecs.push_back(mk(1, 0, 1, 32'h0,   1,  1, 1, 32'h0,   1));
    vecs.push_back(mk(1, 0, 1, 32'h4,   1,  1, 1, 32'h4,   1));
    vecs.push_back(mk(1, 0, 1, 32'h8,   1,  1, 1, 32'h8,   1));
    vecs.push_back(mk(1, 0, 0, 32'h0,   1,  1, 0, 32'h0,   0));
    // Fill to full with decode stalled; fifth offer refused.
    vecs.push_back(mk(1, 0, 1, 32'h0,   0,  1, 1, 32'h0,   1));
    vecs.push_back(mk(1, 0, 1, 32'h4,   0,  1, 1, 32'h0,   2));
    vecs.push_back(mk(1, 0, 1, 32'h8,   0,  1, 1, 32'h0,   3));
    vecs.push_back(mk(1, 0, 1, 32'hC,   0,  0, 1, 32'h0,   4));
    vecs.push_back(mk(1, 0, 1, 32'h10,  0,  0, 1, 32'h0,   4));
    // Drain: pop only while full, then the held offer is accepted.
    vecs.push_back(mk(1, 0, 1, 32'h10,  1,  1, 1, 32'h4,   3));
    vecs.push_back(mk(1, 0, 1, 32'h10,  1,  1, 1, 32'h8,   3));
    vecs.push_back(mk(1, 0, 0, 32'h0,   1,  1, 1, 32'hC,   2));
    vecs.push_back(mk(1, 0, 0, 32'h0,   1,  1, 1, 32'h10,  1));
    vecs.push_back(mk(1, 0, 0, 32'h0,   1,  1, 0, 32'h0,   0));
    // Empty: decode ready is ignored.
    vecs.push_back(mk(1, 0, 0, 32'h0,   1,  1, 0, 32'h0,   0));
    // Preload 3, then push+pop across pointer wrap.
    vecs.push_back(mk(1, 0, 1, 32'h20,  0,  1, 1, 32'h20,  1));
    vecs.push_back(mk(1, 0, 1, 32'h24,  0,  1, 1, 32'h20,  2));
    vecs.push_back(mk(1, 0, 1, 32'h28,  0,  1, 1, 32'h20,  3));
    vecs.push_back(mk(1, 0, 1, 32'h2C,  1,  1, 1, 32'h24,  3));
    vecs.push_back(mk(1, 0, 1, 32'h30,  1,  1, 1, 32'h28,  3));
    vecs.push_back(mk(1, 0, 1, 32'h34,  1,  1, 1, 32'h2C,  3));
    vecs.push_back(mk(1, 0, 1, 32'h38,  1,  1, 1, 32'h30,  3));
    vecs.push_back(mk(1, 0, 1, 32'h3C,  1,  1, 1, 32'h34,  3));
    vecs.push_back(mk(1, 0, 1, 32'h40,  1,  1, 1, 32'h38,  3));
    // Decode stalled: head stable.
    vecs.push_back(mk(1, 0, 0, 32'h0,   0,  1, 1, 32'h38,  3));
    vecs.push_back(mk(1, 0, 0, 32'h0,   0,  1, 1, 32'h38,  3));
    // Flush with offer and decode ready: everything dropped.
    vecs.push_back(mk(1, 1, 1, 32'h50,  1,  1, 0, 32'h0,   0));
    // Flush while empty: stays empty.
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,  1, 0, 32'h0,   0));
    // Next push is the first output after the flush.
    vecs.push_back(mk(1, 0, 1, 32'h60,  0,  1, 1, 32'h60,  1));
    vecs.push_back(mk(1, 0, 0, 32'h0,   1,  1, 0, 32'h0,   0));
    // Fill to full, then flush a full queue.
    vecs.push_back(mk(1, 0, 1, 32'h64,  0,  1, 1, 32'h64,  1));
    vecs.push_back(mk(1, 0, 1, 32'h68,  0,  1, 1, 32'h64,  2));
    vecs.push_back(mk(1, 0, 1, 32'h6C,  0,  1, 1, 32'h64,  3));
    vecs.push_back(mk(1, 0, 1, 32'h70,  0,  0, 1, 32'h64,  4));
    vecs.push_back(mk(1, 1, 1, 32'h74,  0,  1, 0, 32'h0,   0));

    #2;
    foreach (vecs[i]) apply(i, vecs[i]);

    // Asynchronous reset between edges with two entries queued.
    apply(100, mk(1, 0, 1, 32'h80, 0,  1, 1, 32'h80, 1));
    apply(101, mk(1, 0, 1, 32'h84, 0,  1, 1, 32'h80, 2));
    if_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst count",    64'(count),    64'(0));
    check("async_rst id_valid", 64'(id_valid), 64'(0));
    check("async_rst id_pc",    64'(id_pc),    64'(0));
    check("async_rst id_inst",  64'(id_inst),  64'(0));
    check("async_rst if_ready", 64'(if_ready), 64'(1));
    @(posedge clk);
    #1;
    check("rst_hold count", 64'(count), 64'(0));
    // Recovery after release: old entries gone, new push is the head.
    apply(102, mk(1, 0, 1, 32'h90, 0,  1, 1, 32'h90, 1));
    apply(103, mk(1, 0, 0, 32'h0,  1,  1, 0, 32'h0,  0));

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
